stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised, registered N-channel, W-bit stream multiplexer with valid/ready handshake on every input and on the output.
- Next generation of the team's 8:1 single-bit selectors: generalises channel count and data width.
- Adds backpressure, a one-beat output register and a round-robin arbitration mode alongside fixed select.
- Sits between multiple producer channels and a single downstream consumer.

Parameters:
- CH, 8, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SW, 3, select/channel-index width; must equal ceil(log2(CH)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index used in fixed mode.
- in_valid  input  CH  per-channel beat valid.
- in_data  input  CH*W  channel i occupies bits [i*W+W-1 : i*W].
- in_ready  output  CH  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  held beat data.
- out_ch  output  SW  source channel of the held beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - Any held beat is dropped.
  - in_ready is all-zero whenever rst=1.
- Output stage has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = !out_valid || out_ready. The register may load in the same cycle it is drained, giving 1 beat/cycle throughput.
- Grant, combinational:
  - mode=0: grant to sel when sel<CH and in_valid[sel]=1; otherwise no grant. Other channels are never granted.
  - mode=1: grant to the first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod CH; no grant if all in_valid=0.
- in_ready[i] = !rst && load_en && grant_valid && (grant==i).
- A transfer on channel i occurs when in_valid[i] && in_ready[i].
- At the clk edge when load_en=1:
  - with grant: out_valid<=1, out_data<=in_data slice of grant, out_ch<=grant;
  - without grant: out_valid<=0 (data/ch unchanged).
- When load_en=0: all output registers hold; in_ready is all-zero.
- rr_ptr update:
  - mode=1 with a transfer: rr_ptr<=(grant+1) mod CH, wrapping CH-1 -> 0.
  - mode=0: rr_ptr holds.
- Latency: input transfer at edge k -> out_valid/out_data visible after edge k, available to downstream in cycle k+1.
- A held beat is stable (data, ch, valid) until out_ready=1; it never changes under backpressure.
- mode/sel changes take effect at the next arbitration only; a held beat is unaffected.
- Combinational paths: out_ready -> in_ready, and in_valid -> in_ready. There is no path to out_*.
- No X on outputs: out_data is never driven from an out-of-range index.

Decomposition:
- Shared include stream_mux_defs.vh:
  - MODE_FIXED=1'b0, MODE_RR=1'b1;
  - channel index localparam helpers.
- One sub-module, rr_arbiter (params CH, SW; inputs req[CH], ptr[SW]; outputs gnt_valid, gnt[SW]).
  - Purely combinational rotate-priority encoder.
  - Reused for future multi-master blocks.
- Top contains the grant muxing, output register and rr_ptr.

Test Plan:
1. Fixed select: mode=0, sel=5, in_valid=8'hFF, ch5 data 8'hA5, out_ready=1 -> in_ready=8'h20; next cycle out_valid=1, out_data=8'hA5, out_ch=5; steady 1 beat/cycle.
2. Round-robin fairness: mode=1, in_valid=8'hFF constant, out_ready=1 -> out_ch sequence 0,1,...,7,0 (wrap). Then in_valid=8'b1000_0100 from rr_ptr=3 -> grants 2? No: grants 7 then 2 then 7.
3. Backpressure: FULL with out_ch=3, data 8'h3C, out_ready=0 for 4 cycles while in_valid changes -> out_* constant, in_ready=0; out_ready=1 -> same-cycle reload from the next granted channel.
4. Empty/no-grant: mode=0, sel=2, in_valid=8'hFB -> in_ready=0; out_valid falls to 0 after the current beat drains.
5. Reset mid-operation: FULL, rr_ptr=6, assert rst one cycle with in_valid=8'hFF -> in_ready=0 during rst; out_valid=0, out_data=0, out_ch=0 after; first RR grant is channel 0.
6. Parameter sweep: CH=5, W=16, SW=3, mode=0, sel=6 -> never grants, no X on outputs; mode=1 wraps 4 -> 0.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream_mux_rr block: mode encoding, output
// stage states and channel-index helpers.
package stream_mux_rr_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_e;

  // Next channel index after idx, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational rotate-priority encoder. The first requester at
// or above ptr wins; if there is none, the lowest requester overall wins,
// which is the wrap-around part of the rotation.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int CH = 8,
  parameter int SW = 3
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt
);

  int            base;
  logic          hi_found;
  logic [SW-1:0] hi_idx;
  logic [SW-1:0] lo_idx;

  // Find the lowest requester overall and the lowest one at/above ptr.
  always_comb begin
    base      = (int'(ptr) < CH) ? int'(ptr) : 0;
    gnt_valid = 1'b0;
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_valid = 1'b1;
        lo_idx    = SW'(i);
        if (i >= base) begin
          hi_found = 1'b1;
          hi_idx   = SW'(i);
        end
      end
    end
    gnt = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream multiplexer with valid/ready on
// every side, fixed-select or round-robin arbitration, and a one-beat output
// register that can reload in the same cycle it drains.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int CH = 8,
  parameter int W  = 8,
  parameter int SW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*W-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  input  logic            out_ready
);

  ostate_e       state_q;
  logic [W-1:0]  data_q;
  logic [SW-1:0] ch_q;
  logic [SW-1:0] rr_ptr_q;
  logic [SW-1:0] rr_ptr_d;

  logic          rr_gnt_valid;
  logic [SW-1:0] rr_gnt;
  logic          fx_gnt_valid;
  logic          gnt_valid;
  logic [SW-1:0] gnt;
  logic [W-1:0]  gnt_data;
  logic          load_en;

  rr_arbiter #(
    .CH(CH),
    .SW(SW)
  ) u_arb (
    .req      (in_valid),
    .ptr      (rr_ptr_q),
    .gnt_valid(rr_gnt_valid),
    .gnt      (rr_gnt)
  );

  // Fixed-select grant: only a valid, in-range sel can win.
  always_comb begin
    fx_gnt_valid = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (int'(sel) == i && in_valid[i]) fx_gnt_valid = 1'b1;
    end
  end

  assign gnt_valid = (mode == MODE_RR) ? rr_gnt_valid : fx_gnt_valid;
  assign gnt       = (mode == MODE_RR) ? rr_gnt : sel;
  assign load_en   = (state_q == ST_EMPTY) || out_ready;

  // Per-channel accept plus data selection; index compare keeps out_data X-free.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (int'(gnt) == i) begin
        in_ready[i] = !rst && load_en && gnt_valid;
        gnt_data    = in_data[i*W +: W];
      end
    end
  end

  // Round-robin pointer moves past the channel that just transferred.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (mode == MODE_RR && load_en && gnt_valid) begin
      rr_ptr_d = SW'(wrap_inc(int'(gnt), CH));
    end
  end

  // Output stage FSM: EMPTY/FULL with registered beat, channel and pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      ch_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (load_en) begin
        if (gnt_valid) begin
          state_q <= ST_FULL;
          data_q  <= gnt_data;
          ch_q    <= gnt;
        end else begin
          state_q <= ST_EMPTY;
        end
      end
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a vector table for the default 8x8
// configuration, hand sequences for backpressure and mid-run reset, and a
// CH=5/W=16 instance for out-of-range select and wrap-around.
module tb_stream_mux_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel, 8-bit instance
  logic        rst8, mode8, ordy8;
  logic [2:0]  sel8;
  logic [7:0]  iv8, ir8;
  logic [63:0] din8;
  logic        ov8;
  logic [7:0]  od8;
  logic [2:0]  oc8;

  // 5-channel, 16-bit instance
  logic        rst5, mode5, ordy5;
  logic [2:0]  sel5;
  logic [4:0]  iv5, ir5;
  logic [79:0] din5;
  logic        ov5;
  logic [15:0] od5;
  logic [2:0]  oc5;

  stream_mux_rr #(.CH(8), .W(8), .SW(3)) dut8 (
    .clk(clk), .rst(rst8), .mode(mode8), .sel(sel8),
    .in_valid(iv8), .in_data(din8), .in_ready(ir8),
    .out_valid(ov8), .out_data(od8), .out_ch(oc8), .out_ready(ordy8)
  );

  stream_mux_rr #(.CH(5), .W(16), .SW(3)) dut5 (
    .clk(clk), .rst(rst5), .mode(mode5), .sel(sel5),
    .in_valid(iv5), .in_data(din5), .in_ready(ir5),
    .out_valid(ov5), .out_data(od5), .out_ch(oc5), .out_ready(ordy5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] iv;
    logic       ordy;
    logic [7:0] exp_ir;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [2:0] exp_c;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic m, input logic [2:0] s,
                     input logic [7:0] iv, input logic o, input logic [7:0] eir,
                     input logic ev, input logic [7:0] ed, input logic [2:0] ec);
    vec_t v;
    v.name = nm; v.rst = r; v.mode = m; v.sel = s; v.iv = iv; v.ordy = o;
    v.exp_ir = eir; v.exp_v = ev; v.exp_d = ed; v.exp_c = ec;
    vq.push_back(v);
  endtask

  // Drive one cycle on dut8: in_ready is checked before the edge, outputs after.
  task automatic apply8(input string nm, input logic r, input logic m, input logic [2:0] s,
                        input logic [7:0] iv, input logic o, input logic [7:0] eir,
                        input logic ev, input logic [7:0] ed, input logic [2:0] ec);
    rst8 = r; mode8 = m; sel8 = s; iv8 = iv; ordy8 = o;
    #1;
    check({nm, " in_ready"}, 32'(ir8), 32'(eir));
    @(posedge clk);
    #1;
    check({nm, " out_valid"}, 32'(ov8), 32'(ev));
    check({nm, " out_data"}, 32'(od8), 32'(ed));
    check({nm, " out_ch"}, 32'(oc8), 32'(ec));
  endtask

  task automatic apply5(input string nm, input logic r, input logic m, input logic [2:0] s,
                        input logic [4:0] iv, input logic o, input logic [4:0] eir,
                        input logic ev, input logic [15:0] ed, input logic [2:0] ec);
    rst5 = r; mode5 = m; sel5 = s; iv5 = iv; ordy5 = o;
    #1;
    check({nm, " in_ready"}, 32'(ir5), 32'(eir));
    @(posedge clk);
    #1;
    check({nm, " out_valid"}, 32'(ov5), 32'(ev));
    check({nm, " out_data"}, 32'(od5), 32'(ed));
    check({nm, " out_ch"}, 32'(oc5), 32'(ec));
    check({nm, " no_x"}, 32'($isunknown({ov5, od5, oc5})), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) din8[i*8 +: 8] = 8'(8'hA0 + i);
    for (int i = 0; i < 5; i++) din5[i*16 +: 16] = 16'(16'hB000 + i);
    rst5 = 1'b1; mode5 = 1'b0; sel5 = 3'd0; iv5 = '0; ordy5 = 1'b1;

    // name            rst mode sel  in_valid rdy  exp_ir  v   data    ch
    add("reset",       1, 0, 3'd0, 8'hFF, 1, 8'h00, 0, 8'h00, 3'd0);
    add("fixed5_a",    0, 0, 3'd5, 8'hFF, 1, 8'h20, 1, 8'hA5, 3'd5);
    add("fixed5_b",    0, 0, 3'd5, 8'hFF, 1, 8'h20, 1, 8'hA5, 3'd5);
    add("rr_ch0",      0, 1, 3'd0, 8'hFF, 1, 8'h01, 1, 8'hA0, 3'd0);
    add("rr_ch1",      0, 1, 3'd0, 8'hFF, 1, 8'h02, 1, 8'hA1, 3'd1);
    add("rr_ch2",      0, 1, 3'd0, 8'hFF, 1, 8'h04, 1, 8'hA2, 3'd2);
    add("rr_ch3",      0, 1, 3'd0, 8'hFF, 1, 8'h08, 1, 8'hA3, 3'd3);
    add("rr_ch4",      0, 1, 3'd0, 8'hFF, 1, 8'h10, 1, 8'hA4, 3'd4);
    add("rr_ch5",      0, 1, 3'd0, 8'hFF, 1, 8'h20, 1, 8'hA5, 3'd5);
    add("rr_ch6",      0, 1, 3'd0, 8'hFF, 1, 8'h40, 1, 8'hA6, 3'd6);
    add("rr_ch7",      0, 1, 3'd0, 8'hFF, 1, 8'h80, 1, 8'hA7, 3'd7);
    add("rr_wrap0",    0, 1, 3'd0, 8'hFF, 1, 8'h01, 1, 8'hA0, 3'd0);
    add("rr_ch1b",     0, 1, 3'd0, 8'hFF, 1, 8'h02, 1, 8'hA1, 3'd1);
    add("rr_ch2b",     0, 1, 3'd0, 8'hFF, 1, 8'h04, 1, 8'hA2, 3'd2);
    add("rr_sparse7",  0, 1, 3'd0, 8'h84, 1, 8'h80, 1, 8'hA7, 3'd7);
    add("rr_sparse2",  0, 1, 3'd0, 8'h84, 1, 8'h04, 1, 8'hA2, 3'd2);
    add("rr_sparse7b", 0, 1, 3'd0, 8'h84, 1, 8'h80, 1, 8'hA7, 3'd7);
    add("nogrant_a",   0, 0, 3'd2, 8'hFB, 1, 8'h00, 0, 8'hA7, 3'd7);
    add("nogrant_b",   0, 0, 3'd2, 8'hFB, 1, 8'h00, 0, 8'hA7, 3'd7);
    add("nogrant_c",   0, 0, 3'd2, 8'hFB, 0, 8'h00, 0, 8'hA7, 3'd7);

    foreach (vq[k]) begin
      apply8(vq[k].name, vq[k].rst, vq[k].mode, vq[k].sel, vq[k].iv, vq[k].ordy,
             vq[k].exp_ir, vq[k].exp_v, vq[k].exp_d, vq[k].exp_c);
    end

    // Backpressure: held beat from ch3 must not move while out_ready=0.
    din8[31:24] = 8'h3C;
    apply8("bp_load", 0, 0, 3'd3, 8'h08, 1, 8'h08, 1, 8'h3C, 3'd3);
    din8[31:24] = 8'hC3;
    apply8("bp_hold1", 0, 0, 3'd3, 8'hFF, 0, 8'h00, 1, 8'h3C, 3'd3);
    apply8("bp_hold2", 0, 1, 3'd0, 8'h00, 0, 8'h00, 1, 8'h3C, 3'd3);
    apply8("bp_hold3", 0, 1, 3'd5, 8'h55, 0, 8'h00, 1, 8'h3C, 3'd3);
    apply8("bp_hold4", 0, 0, 3'd7, 8'hAA, 0, 8'h00, 1, 8'h3C, 3'd3);
    apply8("bp_reload", 0, 0, 3'd6, 8'h40, 1, 8'h40, 1, 8'hA6, 3'd6);
    din8[31:24] = 8'hA3;

    // Mid-run reset: take ch5 in RR mode (pointer -> 6), then reset.
    apply8("rst_prep", 0, 1, 3'd0, 8'h20, 1, 8'h20, 1, 8'hA5, 3'd5);
    apply8("rst_mid", 1, 1, 3'd0, 8'hFF, 1, 8'h00, 0, 8'h00, 3'd0);
    apply8("rst_first_rr", 0, 1, 3'd0, 8'hFF, 1, 8'h01, 1, 8'hA0, 3'd0);

    // CH=5, W=16: out-of-range selects never grant; round-robin wraps 4 -> 0.
    apply5("c5_reset", 1, 0, 3'd0, 5'h1F, 1, 5'h00, 0, 16'h0000, 3'd0);
    apply5("c5_sel6", 0, 0, 3'd6, 5'h1F, 1, 5'h00, 0, 16'h0000, 3'd0);
    apply5("c5_sel7", 0, 0, 3'd7, 5'h1F, 1, 5'h00, 0, 16'h0000, 3'd0);
    apply5("c5_sel5", 0, 0, 3'd5, 5'h1F, 1, 5'h00, 0, 16'h0000, 3'd0);
    apply5("c5_rr0", 0, 1, 3'd6, 5'h1F, 1, 5'h01, 1, 16'hB000, 3'd0);
    apply5("c5_rr1", 0, 1, 3'd6, 5'h1F, 1, 5'h02, 1, 16'hB001, 3'd1);
    apply5("c5_rr2", 0, 1, 3'd6, 5'h1F, 1, 5'h04, 1, 16'hB002, 3'd2);
    apply5("c5_rr3", 0, 1, 3'd6, 5'h1F, 1, 5'h08, 1, 16'hB003, 3'd3);
    apply5("c5_rr4", 0, 1, 3'd6, 5'h1F, 1, 5'h10, 1, 16'hB004, 3'd4);
    apply5("c5_wrap", 0, 1, 3'd6, 5'h1F, 1, 5'h01, 1, 16'hB000, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
